shift_sum_engine: RTL and testbench

SHIFT_SUM_ENGINE -- requirements
Module: shift_sum_engine

---
 rtl/shift_sum_engine.sv | 94 +++++++++
 tb/tb_shift_sum_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sum_engine.sv
// shift_sum_engine: per-channel sample store streamed column-wise into a sum/average; ports: write (wr_*), run (start, avg_mode), stream (out_valid, out_data), result (sum, done, led), status (busy, ovf)
module shift_sum_engine #(
  parameter int CH = 8,
  parameter int W = 8,
  parameter int DEPTH = 32,
  parameter int SUMW = 32,
  parameter int OFFSET = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [$clog2(CH)-1:0] wr_ch,
  input  logic [W-1:0]          wr_data,
  input  logic                  start,
  input  logic                  avg_mode,
  output logic                  busy,
  output logic                  out_valid,
  output logic [CH*W-1:0]       out_data,
  output logic [SUMW-1:0]       sum,
  output logic                  done,
  output logic                  ovf,
  output logic [7:0]            led
);
  localparam int CHW = $clog2(CH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SH = $clog2(CH * DEPTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state;
  logic [W-1:0] r_mem [CH][DEPTH];
  logic [CW-1:0] r_cnt [CH];
  logic [AW-1:0] r_k;
  logic [SUMW-1:0] r_acc;
  logic r_avg;
  logic w_wr_ok;
  logic w_go;
  logic [AW-1:0] w_k;
  logic [CH*W-1:0] w_col;
  logic [SUMW-1:0] w_csum;
  assign w_wr_ok = wr_en && r_state == IDLE && r_cnt[wr_ch] != CW'(DEPTH);
  assign w_go = r_state == IDLE && start;
  assign w_k = r_state == IDLE ? '0 : r_k;
  assign busy = r_state != IDLE;
  assign led = sum[15:8];
  always_comb begin
    w_col = '0;
    w_csum = '0;
    for (int c = 0; c < CH; c++) begin
      // a write committing on the start edge must already appear in column 0
      w_col[c*W +: W] = (w_wr_ok && wr_ch == CHW'(c) && r_cnt[c] == {1'b0, w_k}) ? wr_data : r_mem[c][w_k];
      w_csum = w_csum + SUMW'(w_col[c*W +: W]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || r_state == DONE) begin
      for (int c = 0; c < CH; c++) begin
        r_cnt[c] <= '0;
        for (int d = 0; d < DEPTH; d++) r_mem[c][d] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_ch][r_cnt[wr_ch][AW-1:0]] <= wr_data;
      r_cnt[wr_ch] <= r_cnt[wr_ch] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k <= '0;
      r_acc <= '0;
      r_avg <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      sum <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= r_state == DONE;
      ovf <= ovf | (wr_en && !w_wr_ok);
      if (w_go) r_avg <= avg_mode;
      if (w_go || r_state == SHIFT) begin
        out_data <= w_col;
        out_valid <= 1'b1;
        r_acc <= (w_go ? '0 : r_acc) + w_csum;
        r_k <= w_k + 1'b1;
        r_state <= (r_state == SHIFT && r_k == AW'(DEPTH - 1)) ? DONE : SHIFT;
      end
      if (r_state == DONE) begin
        sum <= r_avg ? r_acc >> SH : r_acc + SUMW'(OFFSET);
        out_valid <= 1'b0;
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_shift_sum_engine.sv
// tb_shift_sum_engine: directed and randomized checks of shift_sum_engine against a per-channel array model
module tb_shift_sum_engine;
  localparam int CH = 8;
  localparam int W = 8;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst, wr_en, start, avg_mode;
  logic [2:0] wr_ch;
  logic [7:0] wr_data;
  logic busy, out_valid, done, ovf;
  logic [63:0] out_data;
  logic [31:0] sum;
  logic [7:0] led;
  int n_tests = 0;
  int n_fail = 0;
  int m [CH][DEPTH];
  int cnt [CH];
  bit movf;
  shift_sum_engine dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .start(start), .avg_mode(avg_mode), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .sum(sum), .done(done), .ovf(ovf), .led(led)
  );
  always #5 clk = ~clk;
  function automatic void mclear();
    for (int c = 0; c < CH; c++) begin
      cnt[c] = 0;
      for (int d = 0; d < DEPTH; d++) m[c][d] = 0;
    end
  endfunction
  function automatic void mwrite(int ch, int d);
    if (cnt[ch] < DEPTH) begin
      m[ch][cnt[ch]] = d;
      cnt[ch]++;
    end else movf = 1'b1;
  endfunction
  function automatic logic [63:0] ecol(int k);
    logic [63:0] r = '0;
    for (int c = 0; c < CH; c++) r[c*8 +: 8] = 8'(m[c][k]);
    return r;
  endfunction
  function automatic logic [31:0] esum(bit avg);
    longint t = 0;
    for (int c = 0; c < CH; c++)
      for (int d = 0; d < DEPTH; d++) t += m[c][d];
    return avg ? 32'(t / (CH * DEPTH)) : 32'(t + 128);
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int ch, input int d);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1;
    wr_ch = 3'(ch);
    wr_data = 8'(d);
    mwrite(ch, d);
    @(posedge clk);
  endtask
  task automatic fill_rand();
    for (int c = 0; c < CH; c++) begin
      int n = $urandom_range(0, DEPTH);
      for (int d = 0; d < n; d++) wr(c, $urandom_range(0, 255));
    end
  endtask
  task automatic run(input bit avg, input bit w, input int wch, input int wdat,
                     input int rst_at, input int mid_start, input int mid_wr);
    logic [31:0] es;
    @(negedge clk);
    start = 1'b1;
    avg_mode = avg;
    wr_en = w;
    wr_ch = 3'(wch);
    wr_data = 8'(wdat);
    if (w) mwrite(wch, wdat);
    es = esum(avg);
    @(posedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      avg_mode = ~avg;
      chk("busy_run", busy, 1);
      chk("valid_run", out_valid, 1);
      chk($sformatf("col%0d", k), out_data, ecol(k));
      chk("ovf_run", ovf, movf);
      chk("done_run", done, 0);
      if (k == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mclear();
        movf = 1'b0;
        chk("busy_rst", busy, 0);
        chk("valid_rst", out_valid, 0);
        chk("sum_rst", sum, 0);
        chk("data_rst", out_data, 0);
        chk("ovf_rst", ovf, 0);
        return;
      end
      if (k == mid_start) start = 1'b1;
      if (k == mid_wr) begin
        wr_en = 1'b1;
        wr_ch = 3'($urandom_range(0, CH - 1));
        wr_data = 8'($urandom_range(0, 255));
        movf = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    chk("done", done, 1);
    chk("sum", sum, es);
    chk("led", led, es[15:8]);
    chk("busy_end", busy, 0);
    chk("valid_end", out_valid, 0);
    chk("ovf_end", ovf, movf);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("sum_hold", sum, es);
    mclear();
  endtask
  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    start = 1'b0;
    avg_mode = 1'b0;
    wr_ch = '0;
    wr_data = '0;
    movf = 1'b0;
    mclear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sum", sum, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_led", led, 0);
    for (int c = 0; c < CH; c++) for (int d = 0; d < DEPTH; d++) wr(c, 1);
    run(0, 0, 0, 0, -1, -1, -1);
    chk("sum_ones", sum, 384);
    for (int c = 0; c < CH; c++) for (int d = 0; d < DEPTH; d++) wr(c, 255);
    run(0, 0, 0, 0, -1, -1, -1);
    chk("sum_ff", sum, 65408);
    chk("led_ff", led, 8'hFF);
    for (int c = 0; c < CH; c++) for (int d = 0; d < DEPTH; d++) wr(c, 4);
    run(1, 0, 0, 0, -1, -1, -1);
    chk("avg_4", sum, 4);
    for (int d = 0; d < DEPTH + 1; d++) wr(3, $urandom_range(0, 255));
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_full", ovf, 1);
    run(0, 0, 0, 0, -1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      fill_rand();
      run(1'($urandom_range(0, 1)), 0, 0, 0, -1, $urandom_range(1, 29), -1);
    end
    fill_rand();
    run(0, 0, 0, 0, 10, -1, -1);
    fill_rand();
    run(1'($urandom_range(0, 1)), 0, 0, 0, -1, -1, -1);
    run(0, 1, 0, 5, -1, -1, -1);
    chk("sum_same_edge", sum, 133);
    fill_rand();
    run(0, 0, 0, 0, -1, -1, 7);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    wr_en = 1'b1;
    wr_ch = 3'd2;
    wr_data = 8'd77;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    mclear();
    movf = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_ovf", ovf, 0);
    run(0, 0, 0, 0, -1, -1, -1);
    chk("sum_empty", sum, 128);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
